exh_vector_sequencer: RTL and testbench

Hardware controller that runs an exhaustive input sweep on a small combinational/sequential benchmark under test (trojan-detection flow). Drives every input vector 0..2^N_IN-1 in ascending order, waits a programmable settle time, samples the DUT output, and streams (vector, response) records out over a valid/ready handshake to the log/compare stage. Replaces per-vector testbench stimulus with one reusable sequencer shared by all benchmark wrappers.

---
 rtl/exh_vector_sequencer.sv | 133 +++++++++++++
 tb/tb_exh_vector_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exh_vector_sequencer.sv
// Exhaustive input-sweep sequencer: drives vectors 0..2^N_IN-1 into a benchmark, samples after a settle delay, streams records.
// Optional VSEQ_MISR_EN adds a 16-bit MISR signature over the accepted responses.
module exh_vector_sequencer #(
    parameter int N_IN       = 5,
    parameter int OUT_W      = 1,
    parameter int SETTLE_CYC = 1,
    parameter int SETTLE_W   = 4
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [N_IN-1:0]  rec_vec,
    output logic [OUT_W-1:0] rec_resp,
    output logic             rec_last,
    output logic             busy,
    output logic             done
`ifdef VSEQ_MISR_EN
    ,
    output logic [15:0]      signature
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        EMIT,
        DONE
    } state_t;

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [N_IN:0]       LAST_VEC    = (N_IN + 1)'((1 << N_IN) - 1);

    state_t             state;
    state_t             state_next;
    logic [N_IN:0]      vec_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic               launch;
    logic               handshake;

    // start only launches from a resting state; abort outranks both start and the handshake
    assign launch    = start && !abort && (state == IDLE || state == DONE);
    assign handshake = (state == EMIT) && rec_ready && !abort;

    always_ff @(posedge CK) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_next = APPLY;
                APPLY:      state_next = SETTLE;
                SETTLE:     if (settle_cnt == '0) state_next = EMIT;
                EMIT:       if (rec_ready) state_next = rec_last ? DONE : APPLY;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        rec_valid = (state == EMIT);
        busy      = (state == APPLY) || (state == SETTLE) || (state == EMIT);
        done      = (state == DONE);
    end

    always_ff @(posedge CK) begin
        if (!reset) begin
            dut_in     <= '0;
            rec_vec    <= '0;
            rec_resp   <= '0;
            rec_last   <= 1'b0;
            vec_cnt    <= '0;
            settle_cnt <= '0;
        end else if (abort) begin
            dut_in <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) vec_cnt <= '0;
                end
                APPLY: begin
                    dut_in     <= vec_cnt[N_IN-1:0];
                    settle_cnt <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        rec_resp <= dut_out;
                        rec_vec  <= dut_in;
                        rec_last <= (vec_cnt == LAST_VEC);
                    end else begin
                        settle_cnt <= settle_cnt - SETTLE_W'(1);
                    end
                end
                EMIT: begin
                    if (rec_ready && !rec_last) vec_cnt <= vec_cnt + (N_IN + 1)'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef VSEQ_MISR_EN
    // x^16+x^12+x^3+x+1: shift left, fold taps 0x100B on msb, xor in the response
    always_ff @(posedge CK) begin
        if (!reset) begin
            signature <= 16'hFFFF;
        end else if (launch) begin
            signature <= 16'hFFFF;
        end else if (handshake) begin
            signature <= {signature[14:0], 1'b0}
                       ^ (signature[15] ? 16'h100B : 16'h0000)
                       ^ 16'(rec_resp);
        end
    end
`else
    logic unused_ctl;
    assign unused_ctl = launch ^ handshake;
`endif

endmodule

// File: tb/tb_exh_vector_sequencer.sv
// Scoreboard bench for exh_vector_sequencer: directed sweeps, backpressure, abort, mid-sweep reset, settle timing.
module tb_exh_vector_sequencer;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic fm(input logic [4:0] v);
        return v[0] ^ v[4];
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h100B;
        n[0] = n[0] ^ d;
        return n;
    endfunction

    // main instance: default params, combinational parity DUT
    logic       reset = 1'b0, start = 1'b0, abort = 1'b0, rec_ready = 1'b1;
    logic [4:0] dut_in, rec_vec;
    logic       dut_out, rec_valid, rec_resp, rec_last, busy, done;
    logic [15:0] sig_a;
    assign dut_out = ^dut_in;

    exh_vector_sequencer u_a (
        .CK(CK), .reset(reset), .start(start), .abort(abort),
        .dut_in(dut_in), .dut_out(dut_out),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_vec(rec_vec),
        .rec_resp(rec_resp), .rec_last(rec_last), .busy(busy), .done(done)
`ifdef VSEQ_MISR_EN
        , .signature(sig_a)
`endif
    );
`ifndef VSEQ_MISR_EN
    assign sig_a = 16'hFFFF;
`endif

    // settle-timing instances driving a DUT with two registers of latency
    logic       start_bc = 1'b0;
    logic [4:0] dut_in_b, vec_b, dut_in_c, vec_c;
    logic       rv_b, resp_b, last_b, busy_b, done_b;
    logic       rv_c, resp_c, last_c, busy_c, done_c;
    logic       d1b = 1'b0, d2b = 1'b0, d1c = 1'b0, d2c = 1'b0;
    logic [15:0] sig_b, sig_c;
    always @(posedge CK) begin
        d1b <= fm(dut_in_b);
        d2b <= d1b;
        d1c <= fm(dut_in_c);
        d2c <= d1c;
    end

    exh_vector_sequencer #(.SETTLE_CYC(3)) u_b (
        .CK(CK), .reset(reset), .start(start_bc), .abort(1'b0),
        .dut_in(dut_in_b), .dut_out(d2b),
        .rec_valid(rv_b), .rec_ready(1'b1), .rec_vec(vec_b),
        .rec_resp(resp_b), .rec_last(last_b), .busy(busy_b), .done(done_b)
`ifdef VSEQ_MISR_EN
        , .signature(sig_b)
`endif
    );

    exh_vector_sequencer #(.SETTLE_CYC(1)) u_c (
        .CK(CK), .reset(reset), .start(start_bc), .abort(1'b0),
        .dut_in(dut_in_c), .dut_out(d2c),
        .rec_valid(rv_c), .rec_ready(1'b1), .rec_vec(vec_c),
        .rec_resp(resp_c), .rec_last(last_c), .busy(busy_c), .done(done_c)
`ifdef VSEQ_MISR_EN
        , .signature(sig_c)
`endif
    );
`ifndef VSEQ_MISR_EN
    assign sig_b = 16'hFFFF;
    assign sig_c = 16'hFFFF;
`endif

    typedef struct packed {
        logic [4:0] vec;
        logic       resp;
        logic       last;
    } rec_t;

    rec_t        q[$];
    rec_t        qb[$];
    logic [15:0] misr_model = 16'hFFFF;
    int          nb = 0, nc = 0, mism_c = 0;

    task automatic push_sweep(input int upto);
        rec_t r;
        misr_model = 16'hFFFF;
        for (int v = 0; v < upto; v++) begin
            r.vec  = 5'(v);
            r.resp = ^(5'(v));
            r.last = (v == 31);
            q.push_back(r);
        end
    endtask

    always @(negedge CK) begin
        if (reset && rec_valid && rec_ready && !abort) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rec_unexpected actual=%0h required=none", rec_vec);
            end else begin
                rec_t e;
                e = q.pop_front();
                chk("rec_vec", 32'(rec_vec), 32'(e.vec));
                chk("rec_resp", 32'(rec_resp), 32'(e.resp));
                chk("rec_last", 32'(rec_last), 32'(e.last));
                misr_model = misr_step(misr_model, e.resp);
            end
        end
    end

    always @(negedge CK) begin
        if (reset && rv_b) begin
            nb++;
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL settle3_unexpected actual=%0h required=none", vec_b);
            end else begin
                rec_t e;
                e = qb.pop_front();
                chk("settle3_vec", 32'(vec_b), 32'(e.vec));
                chk("settle3_resp", 32'(resp_b), 32'(e.resp));
            end
        end
        if (reset && rv_c) begin
            nc++;
            if (resp_c !== fm(vec_c)) mism_c++;
        end
    end

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_vec(input logic [4:0] v, input string name);
        int n = 0;
        while (dut_in !== v && n < 200) begin step(); n++; end
        if (n >= 200) chk({name, "_timeout"}, 32'(dut_in), 32'(v));
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (rec_valid !== 1'b1 && n < 50) begin step(); n++; end
        if (n >= 50) chk({name, "_timeout"}, 32'(rec_valid), 32'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 400) begin step(); n++; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rec_t r;

        repeat (3) @(posedge CK);
        #1;
        chk("rst_dut_in", 32'(dut_in), 32'd0);
        chk("rst_rec_valid", 32'(rec_valid), 32'd0);
        chk("rst_rec_vec", 32'(rec_vec), 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_rec_resp_last", {30'd0, rec_resp, rec_last}, 32'd0);
`ifdef VSEQ_MISR_EN
        chk("rst_signature", 32'(sig_a), 32'hFFFF);
`endif
        reset = 1'b1;
        step();

        // full sweep, ready tied high
        push_sweep(32);
        pulse_start();
        chk("apply_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("done_latency", 32'(n), 32'd96);
        chk("sweep1_all_records", 32'(q.size()), 32'd0);
        chk("done_holds_dut_in", 32'(dut_in), 32'd31);
        chk("done_busy", 32'(busy), 32'd0);
`ifdef VSEQ_MISR_EN
        chk("signature_sweep1", 32'(sig_a), 32'(misr_model));
`endif

        // backpressure on vector 3
        push_sweep(32);
        pulse_start();
        wait_vec(5'd3, "bp_vec");
        rec_ready = 1'b0;
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            chk("bp_rec_valid", 32'(rec_valid), 32'd1);
            chk("bp_rec_vec", 32'(rec_vec), 32'd3);
            chk("bp_rec_resp", 32'(rec_resp), 32'd0);
            chk("bp_dut_in", 32'(dut_in), 32'd3);
            step();
        end
        rec_ready = 1'b1;
        wait_done(n);
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_all_records", 32'(q.size()), 32'd0);

        // abort while vector 10 is waiting in EMIT, with ready raised the same cycle
        push_sweep(10);
        pulse_start();
        wait_vec(5'd10, "abort_vec");
        rec_ready = 1'b0;
        wait_valid("abort_valid");
        chk("abort_pre_vec", 32'(rec_vec), 32'd10);
        abort = 1'b1;
        rec_ready = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_rec_valid", 32'(rec_valid), 32'd0);
        chk("abort_dut_in", 32'(dut_in), 32'd0);
        chk("abort_done_busy", {30'd0, busy, done}, 32'd0);
        chk("abort_records", 32'(q.size()), 32'd0);
        step();
        chk("abort_stays_idle", 32'(busy), 32'd0);

        push_sweep(32);
        pulse_start();
`ifdef VSEQ_MISR_EN
        chk("signature_reseed", 32'(sig_a), 32'hFFFF);
`endif
        wait_done(n);
        chk("restart_latency", 32'(n), 32'd96);
        chk("restart_all_records", 32'(q.size()), 32'd0);
`ifdef VSEQ_MISR_EN
        chk("signature_restart", 32'(sig_a), 32'(misr_model));
`endif

        // synchronous reset in SETTLE of vector 17, start held during reset
        push_sweep(17);
        pulse_start();
        wait_vec(5'd17, "rst_vec");
        reset = 1'b0;
        start = 1'b1;
        step();
        chk("midrst_dut_in", 32'(dut_in), 32'd0);
        chk("midrst_rec_vec", 32'(rec_vec), 32'd0);
        chk("midrst_rec_valid", 32'(rec_valid), 32'd0);
        chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("midrst_resp_last", {30'd0, rec_resp, rec_last}, 32'd0);
        chk("midrst_records", 32'(q.size()), 32'd0);
        reset = 1'b1;
        start = 1'b0;
        step();
        chk("midrst_start_ignored", 32'(busy), 32'd0);

        // settle-time sweeps against the delayed DUT model
        for (int v = 0; v < 32; v++) begin
            r.vec  = 5'(v);
            r.resp = fm(5'(v));
            r.last = (v == 31);
            qb.push_back(r);
        end
        start_bc = 1'b1;
        step();
        start_bc = 1'b0;
        n = 0;
        while (!(done_b === 1'b1 && done_c === 1'b1) && n < 400) begin step(); n++; end
        chk("settle3_done", 32'(done_b), 32'd1);
        chk("settle3_count", 32'(nb), 32'd32);
        chk("settle3_all_records", 32'(qb.size()), 32'd0);
        chk("settle1_count", 32'(nc), 32'd32);
        chk("settle1_detects_stale", 32'(mism_c > 0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
